// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and constants for the add/sub arbiter.
// FSM state encoding, operation modes and saturation limits.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int ADDSUB_DW = 8;

    localparam logic [ADDSUB_DW-1:0] SAT_POS = 8'h7F;
    localparam logic [ADDSUB_DW-1:0] SAT_NEG = 8'h80;

endpackage

// File: rtl/addsub_unit.sv
// addsub_unit: combinational DW-bit adder/subtractor.
// Subtract is a + ~b + 1; v flags signed overflow, carry is dropped.
module addsub_unit
    import addsub_pkg::*;
#(
    parameter int DW = ADDSUB_DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          mode,
    output logic [DW-1:0] result,
    output logic          v
);

    logic [DW-1:0] b_eff;
    logic [DW-1:0] cin;

    assign b_eff  = (mode == MODE_ADD) ? b : ~b;
    assign cin    = {{(DW-1){1'b0}}, (mode == MODE_SUB)};
    assign result = a + b_eff + cin;

    assign v = (a[DW-1] == b_eff[DW-1])
             && (result[DW-1] != a[DW-1]);

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one add/sub unit.
// Macro ADDSUB_SATURATE_EN clamps overflowing results to the signed limits.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = ADDSUB_DW,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    input  logic [N_REQ-1:0]    req_mode,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [DW-1:0]       rsp_result,
    output logic                rsp_v,
    output logic                busy
);

    state_t         state;
    state_t         nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic           found;
    logic [IDW-1:0] cap_id;
    logic [DW-1:0]  cap_a;
    logic [DW-1:0]  cap_b;
    logic           cap_mode;
    logic [DW-1:0]  u_res;
    logic           u_v;
    logic [DW-1:0]  fin_res;

    // First valid index after ptr, wrapping; MSB of result = found.
    function automatic logic [IDW:0] rr_pick(
        input logic [N_REQ-1:0] vld,
        input logic [IDW-1:0]   ptr
    );
        logic [IDW:0] r;
        int           j;
        r = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!r[IDW] && vld[j]) begin
                r = {1'b1, IDW'(j)};
            end
        end
        return r;
    endfunction

    assign {found, grant} = rr_pick(req_valid, rr_ptr);
    assign busy = (state != IDLE);

    addsub_unit #(.DW(DW)) u_unit (
        .a      (cap_a),
        .b      (cap_b),
        .mode   (cap_mode),
        .result (u_res),
        .v      (u_v)
    );

`ifdef ADDSUB_SATURATE_EN
    assign fin_res = !u_v       ? u_res :
                     cap_a[DW-1] ? {1'b1, {(DW-1){1'b0}}}
                                 : {1'b0, {(DW-1){1'b1}}};
`else
    assign fin_res = u_res;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next state and the single-cycle accept strobe.
    always_comb begin
        nxt       = state;
        req_ready = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    req_ready[grant] = 1'b1;
                    nxt              = EXEC;
                end
            end
            EXEC:    nxt = RESP;
            RESP:    if (rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Operand capture, response register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= IDW'(N_REQ - 1);
            cap_id     <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_mode   <= MODE_ADD;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_v      <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                cap_id   <= grant;
                cap_a    <= req_a[grant*DW +: DW];
                cap_b    <= req_b[grant*DW +: DW];
                cap_mode <= req_mode[grant];
            end
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= cap_id;
                rsp_result <= fin_res;
                rsp_v      <= u_v;
                rr_ptr     <= cap_id;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
